// File: rtl/buf_load_control_pkg.sv
// Shared definitions for the buffer load controller: FSM encoding,
// buffer target codes and the default packing factor of the stream words.
package buf_load_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [1:0] TGT_W0 = 2'b00;
    localparam logic [1:0] TGT_W1 = 2'b01;
    localparam logic [1:0] TGT_A0 = 2'b10;
    localparam logic [1:0] TGT_A1 = 2'b11;

    // int8 elements packed into one buffer word
    localparam int NDATA = 4;

    // width of the word counter and of the latched word total
    localparam int CNT_W = 12;

endpackage

// File: rtl/buf_load_control.sv
// Streams num_tiles ROWxCOL int8 tiles from a valid/ready word stream into
// one of four on-chip buffers, one registered write per accepted word.
module buf_load_control #(
    parameter int ROW             = 8,
    parameter int COL             = 8,
    parameter int BRAM_ADDR_WIDTH = 11,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int NDATA           = buf_load_control_pkg::NDATA
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [1:0]                 target,
    input  logic [7:0]                 num_tiles,
    input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_DATA_WIDTH-1:0] buf_wdata,
    output logic                       w_buf0_en,
    output logic                       w_buf0_we,
    output logic [BRAM_ADDR_WIDTH-1:0] w_buf0_addr,
    output logic                       w_buf1_en,
    output logic                       w_buf1_we,
    output logic [BRAM_ADDR_WIDTH-1:0] w_buf1_addr,
    output logic                       a_buf0_en,
    output logic                       a_buf0_we,
    output logic [BRAM_ADDR_WIDTH-1:0] a_buf0_addr,
    output logic                       a_buf1_en,
    output logic                       a_buf1_we,
    output logic [BRAM_ADDR_WIDTH-1:0] a_buf1_addr
);

    import buf_load_control_pkg::state_t;
    import buf_load_control_pkg::ST_IDLE;
    import buf_load_control_pkg::ST_LOAD;
    import buf_load_control_pkg::ST_FIN;
    import buf_load_control_pkg::TGT_W0;
    import buf_load_control_pkg::TGT_W1;
    import buf_load_control_pkg::TGT_A0;
    import buf_load_control_pkg::TGT_A1;
    import buf_load_control_pkg::CNT_W;

    localparam int AW             = BRAM_ADDR_WIDTH;
    localparam int WORDS_PER_TILE = ROW * COL / NDATA;

    state_t                 state;
    logic [1:0]             tgt;
    logic [AW-1:0]          base;
    logic [CNT_W-1:0]       total;
    logic [CNT_W-1:0]       count;
    logic [3:0]             en_r;
    logic [3:0][AW-1:0]     addr_r;

    logic [3:0]             sel;
    logic [CNT_W-1:0]       start_total;
    logic                   accept;
    logic                   last_word;
    logic [AW-1:0]          waddr;

    assign start_total = CNT_W'(num_tiles * WORDS_PER_TILE);
    assign accept      = s_valid & s_ready;
    assign last_word   = (count == total - CNT_W'(1));
    // address arithmetic is naturally modulo 2^AW
    assign waddr       = base + AW'(count);

    always_comb begin
        sel = 4'b0000;
        case (tgt)
            TGT_W0:  sel = 4'b0001;
            TGT_W1:  sel = 4'b0010;
            TGT_A0:  sel = 4'b0100;
            TGT_A1:  sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            tgt       <= '0;
            base      <= '0;
            total     <= '0;
            count     <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            buf_wdata <= '0;
            en_r      <= '0;
            addr_r    <= '0;
        end else begin
            en_r <= '0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tgt    <= target;
                        base   <= base_addr;
                        total  <= start_total;
                        count  <= '0;
                        busy   <= 1'b1;
                        // a new load owns no address yet; older targets go quiet
                        addr_r <= '0;
                        if (start_total == '0) begin
                            state <= ST_FIN;
                        end else begin
                            state   <= ST_LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        buf_wdata <= s_data;
                        en_r      <= sel;
                        for (int i = 0; i < 4; i++) begin
                            if (sel[i]) addr_r[i] <= waddr;
                        end
                        count <= count + CNT_W'(1);
                        if (last_word) begin
                            s_ready <= 1'b0;
                            state   <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign w_buf0_en   = en_r[0];
    assign w_buf0_we   = en_r[0];
    assign w_buf0_addr = addr_r[0];
    assign w_buf1_en   = en_r[1];
    assign w_buf1_we   = en_r[1];
    assign w_buf1_addr = addr_r[1];
    assign a_buf0_en   = en_r[2];
    assign a_buf0_we   = en_r[2];
    assign a_buf0_addr = addr_r[2];
    assign a_buf1_en   = en_r[3];
    assign a_buf1_we   = en_r[3];
    assign a_buf1_addr = addr_r[3];

endmodule

// File: tb/tb_buf_load_control.sv
// Randomized bench for buf_load_control: each load's expected timeline
// (acceptances, writes, ready/busy/done windows) is derived from the valid pattern.
module tb_buf_load_control;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int WPT  = 16;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [1:0]    target;
    logic [7:0]    num_tiles;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready, busy, done;
    logic [DW-1:0] buf_wdata;
    logic          w_buf0_en, w_buf0_we, w_buf1_en, w_buf1_we;
    logic          a_buf0_en, a_buf0_we, a_buf1_en, a_buf1_we;
    logic [AW-1:0] w_buf0_addr, w_buf1_addr, a_buf0_addr, a_buf1_addr;

    buf_load_control dut (
        .clk(clk), .rstn(rstn), .start(start), .target(target),
        .num_tiles(num_tiles), .base_addr(base_addr),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .buf_wdata(buf_wdata),
        .w_buf0_en(w_buf0_en), .w_buf0_we(w_buf0_we), .w_buf0_addr(w_buf0_addr),
        .w_buf1_en(w_buf1_en), .w_buf1_we(w_buf1_we), .w_buf1_addr(w_buf1_addr),
        .a_buf0_en(a_buf0_en), .a_buf0_we(a_buf0_we), .a_buf0_addr(a_buf0_addr),
        .a_buf1_en(a_buf1_en), .a_buf1_we(a_buf1_we), .a_buf1_addr(a_buf1_addr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // per-load plan: valid pattern, data, and which word each cycle hands over
    bit            v       [MAXC];
    logic [DW-1:0] d       [MAXC];
    int            acc_idx [MAXC];
    logic [AW-1:0] m_addr  [4];
    logic [DW-1:0] m_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_outputs(input string pfx, input bit e_ready, input bit e_busy,
                               input bit e_done, input logic [3:0] e_en, input bit chk_data);
        logic [AW-1:0] ga [4];
        ga[0] = w_buf0_addr; ga[1] = w_buf1_addr; ga[2] = a_buf0_addr; ga[3] = a_buf1_addr;
        chk({pfx, " s_ready"}, 64'(s_ready), 64'(e_ready));
        chk({pfx, " busy"},    64'(busy),    64'(e_busy));
        chk({pfx, " done"},    64'(done),    64'(e_done));
        chk({pfx, " en"}, 64'({a_buf1_en, a_buf0_en, w_buf1_en, w_buf0_en}), 64'(e_en));
        chk({pfx, " we"}, 64'({a_buf1_we, a_buf0_we, w_buf1_we, w_buf0_we}), 64'(e_en));
        for (int b = 0; b < 4; b++)
            chk($sformatf("%s addr%0d", pfx, b), 64'(ga[b]), 64'(m_addr[b]));
        if (chk_data) chk({pfx, " wdata"}, 64'(buf_wdata), 64'(m_wdata));
    endtask

    // mode 0: valid always, data = cycle index; 1: valid toggles; 2: random valid.
    // rst_word >= 0 pulls rstn low in the cycle that word is handed over.
    task automatic run_load(input string name, input logic [1:0] tgt, input int tiles,
                            input logic [AW-1:0] base, input int mode, input int rst_word);
        int total, k, last_c, rst_c, c;
        logic [3:0] e_en;
        total = tiles * WPT; k = 0; last_c = -1; rst_c = -1;
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0:       v[i] = 1'b1;
                1:       v[i] = (i % 2 == 0);
                default: v[i] = (($urandom % 3) != 0) || (i > MAXC - 200);
            endcase
            d[i] = (mode == 0) ? DW'(i) : $urandom;
            acc_idx[i] = -1;
            if (v[i] && k < total) begin
                acc_idx[i] = k;
                if (k == rst_word) rst_c = i;
                k++;
                if (k == total) last_c = i;
            end
        end

        @(posedge clk); #1;
        start = 1'b1; target = tgt; num_tiles = 8'(tiles); base_addr = base;
        s_valid = 1'($urandom); s_data = $urandom;
        @(posedge clk); #1;
        c = 0;
        while (1) begin
            // stray starts and changing request fields must have no effect
            start     = (c <= last_c + 1) && ($urandom % 4 == 0);
            target    = 2'($urandom);
            num_tiles = 8'($urandom);
            base_addr = AW'($urandom);
            s_valid   = (c <= last_c) ? v[c] : 1'($urandom);
            s_data    = d[c];
            if (rst_c >= 0 && c == rst_c) rstn = 1'b0;
            if (c == 0) for (int b = 0; b < 4; b++) m_addr[b] = '0;
            e_en = '0;
            if (c > 0 && acc_idx[c-1] >= 0) begin
                e_en[tgt]   = 1'b1;
                m_addr[tgt] = AW'(int'(base) + acc_idx[c-1]);
                m_wdata     = d[c-1];
            end
            @(negedge clk);
            chk_outputs(name, c <= last_c, c <= last_c + 1, c == last_c + 2, e_en, e_en != 0);
            if (rst_c >= 0 && c == rst_c) break;
            if (c == last_c + 3) break;
            @(posedge clk); #1;
            c++;
        end
        if (rst_c >= 0) begin
            @(posedge clk); #1;
            rstn = 1'b1; start = 1'b0;
            for (int b = 0; b < 4; b++) m_addr[b] = '0;
            m_wdata = '0;
            @(negedge clk);
            chk_outputs({name, " after rst"}, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; target = '0; num_tiles = '0; base_addr = '0;
        s_valid = 1'b0; s_data = '0;
        for (int b = 0; b < 4; b++) m_addr[b] = '0;
        m_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk_outputs("reset", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

        run_load("w0_seq",   2'b00, 1, AW'(0),    0, -1);
        run_load("a1_tog",   2'b11, 2, AW'(100),  1, -1);
        run_load("zero",     2'($urandom), 0, AW'($urandom), 2, -1);
        run_load("a0_wrap",  2'b10, 1, AW'(2040), 0, -1);
        run_load("w1_rst",   2'b01, 1, AW'(50),   0, 5);
        run_load("w1_after", 2'b01, 1, AW'(50),   0, -1);
        run_load("a0_rst",   2'b10, 2, AW'(2045), 2, 20);
        for (int n = 0; n < 10; n++)
            run_load($sformatf("rand%0d", n), 2'($urandom), $urandom_range(0, 5),
                     AW'($urandom), 2, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
